// File: rtl/id_fwd_interlock_if.sv
// Decode-stage operand bus: IF handoff, regfile read ports, forwarding stages and ID outputs.
interface id_fwd_interlock_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned CNT_W   = 16
);
  logic [STALL_W-1:0]        stall;
  logic                      if_ce;
  logic [31:0]               if_pc;
  logic [31:0]               inst_sram_rdata;
  logic [NUM_SRC-1:0]        src_used;
  logic [5*NUM_SRC-1:0]      rf_raddr;
  logic [DATA_W*NUM_SRC-1:0] rf_rdata;
  logic [NUM_FWD-1:0]        fwd_we;
  logic [5*NUM_FWD-1:0]      fwd_waddr;
  logic [DATA_W*NUM_FWD-1:0] fwd_wdata;
  logic [NUM_FWD-1:0]        fwd_pend;
  logic                      perf_clr;
  logic                      id_valid;
  logic [31:0]               id_pc;
  logic [31:0]               id_inst;
  logic [DATA_W*NUM_SRC-1:0] src_data;
  logic                      stallreq;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output stall, if_ce, if_pc, inst_sram_rdata, src_used, rf_rdata,
           fwd_we, fwd_waddr, fwd_wdata, fwd_pend, perf_clr,
    input  rf_raddr, id_valid, id_pc, id_inst, src_data, stallreq, stall_cnt
  );

  modport slave (
    input  stall, if_ce, if_pc, inst_sram_rdata, src_used, rf_rdata,
           fwd_we, fwd_waddr, fwd_wdata, fwd_pend, perf_clr,
    output rf_raddr, id_valid, id_pc, id_inst, src_data, stallreq, stall_cnt
  );
endinterface

// File: rtl/id_fwd_interlock.sv
// IF->ID register with instruction replay buffer, priority operand forwarding,
// load-use interlock and saturating stall-cycle counter.
module id_fwd_interlock #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  id_fwd_interlock_if.slave bus
);

  logic               id_valid_q;
  logic [31:0]        id_pc_q;
  logic [31:0]        inst_buf;
  logic               buf_vld;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [31:0]        id_inst;
  logic [NUM_SRC-1:0] hazard;
  logic               stallreq;
  logic               unused_stall_bits;

  assign unused_stall_bits = ^{bus.stall[0], bus.stall[STALL_W-1:3]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      inst_buf   <= '0;
      buf_vld    <= 1'b0;
    end else if (bus.stall[1] && !bus.stall[2]) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      buf_vld    <= 1'b0;
    end else if (!bus.stall[1]) begin
      id_valid_q <= bus.if_ce;
      id_pc_q    <= bus.if_pc;
      buf_vld    <= 1'b0;
    end else if (!buf_vld) begin
      // ID held: the SRAM only returns the word for one cycle, so keep it here
      inst_buf <= bus.inst_sram_rdata;
      buf_vld  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (bus.perf_clr) begin
      stall_cnt_q <= '0;
    end else if (stallreq && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign id_inst = !id_valid_q ? '0 : (buf_vld ? inst_buf : bus.inst_sram_rdata);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
    logic              haz;

    assign addr = id_inst[25-5*i -: 5];

    // Walk oldest to youngest so the youngest matching stage overrides.
    always_comb begin
      data = bus.rf_rdata[i*DATA_W +: DATA_W];
      haz  = 1'b0;
      for (int unsigned k = NUM_FWD; k > 0; k--) begin
        if (bus.fwd_we[k-1] && (bus.fwd_waddr[(k-1)*5 +: 5] == addr)) begin
          data = bus.fwd_wdata[(k-1)*DATA_W +: DATA_W];
          haz  = bus.fwd_pend[k-1];
        end
      end
      if (addr == 5'd0) begin
        data = '0;
        haz  = 1'b0;
      end
    end

    assign bus.rf_raddr[i*5 +: 5]           = addr;
    assign bus.src_data[i*DATA_W +: DATA_W] = data;
    assign hazard[i]                        = haz;
  end

  assign stallreq = id_valid_q & (|(bus.src_used & hazard));

  assign bus.id_valid  = id_valid_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_inst   = id_inst;
  assign bus.stallreq  = stallreq;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_fwd_interlock.sv
// Directed and randomized bench for id_fwd_interlock against a behavioural decode-slot model.
module tb_id_fwd_interlock;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned NUM_FWD = 3;
  localparam int unsigned STALL_W = 6;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_pass = 0, n_fail = 0, n_total = 0;

  always #5 clk = ~clk;

  id_fwd_interlock_if #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD),
                        .STALL_W(STALL_W), .CNT_W(CNT_W)) bus ();

  id_fwd_interlock #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD),
                     .STALL_W(STALL_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Regfile model answering the read ports combinationally
  logic [DATA_W-1:0] rf_mem [32];
  always_comb begin
    bus.rf_rdata = '0;
    for (int i = 0; i < NUM_SRC; i++)
      bus.rf_rdata[i*DATA_W +: DATA_W] = rf_mem[bus.rf_raddr[i*5 +: 5]];
  end

  // Reference model of the decode slot
  bit          m_valid, m_bvld, m_sr;
  logic [31:0] m_pc, m_buf;
  int unsigned m_cnt;

  task automatic m_reset();
    m_valid = 1'b0; m_bvld = 1'b0; m_sr = 1'b0;
    m_pc = '0; m_buf = '0; m_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 11'd0};
  endfunction

  // First (youngest) writer of the register wins; $zero is hardwired.
  function automatic void fwd_ref(input logic [4:0] a, output logic [DATA_W-1:0] d, output bit h);
    d = rf_mem[a];
    h = 1'b0;
    if (a == 5'd0) begin
      d = '0;
      return;
    end
    for (int k = 0; k < NUM_FWD; k++) begin
      if (bus.fwd_we[k] && bus.fwd_waddr[k*5 +: 5] == a) begin
        d = bus.fwd_wdata[k*DATA_W +: DATA_W];
        h = bus.fwd_pend[k];
        return;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    logic [31:0]               inst;
    logic [4:0]                a;
    logic [DATA_W-1:0]         d;
    bit                        h;
    logic [DATA_W*NUM_SRC-1:0] e_src;
    logic [5*NUM_SRC-1:0]      e_raddr;
    inst = m_valid ? (m_bvld ? m_buf : bus.inst_sram_rdata) : 32'h0;
    e_src = '0; e_raddr = '0; m_sr = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      a = inst[25-5*i -: 5];
      fwd_ref(a, d, h);
      e_raddr[i*5 +: 5] = a;
      e_src[i*DATA_W +: DATA_W] = d;
      if (bus.src_used[i] && h) m_sr = 1'b1;
    end
    m_sr = m_sr && m_valid;
    chk({tag, "/id_valid"},  bus.id_valid,  m_valid);
    chk({tag, "/id_pc"},     bus.id_pc,     m_pc);
    chk({tag, "/id_inst"},   bus.id_inst,   inst);
    chk({tag, "/rf_raddr"},  bus.rf_raddr,  e_raddr);
    chk({tag, "/src_data"},  bus.src_data,  e_src);
    chk({tag, "/stallreq"},  bus.stallreq,  m_sr);
    chk({tag, "/stall_cnt"}, bus.stall_cnt, m_cnt[CNT_W-1:0]);
  endtask

  task automatic step_check(input string tag);
    #1;
    check_all(tag);
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic tick();
    if (bus.perf_clr) m_cnt = 0;
    else if (m_sr && m_cnt < CNT_MAX) m_cnt++;
    case ({bus.stall[2], bus.stall[1]})
      2'b01: begin m_valid = 1'b0; m_pc = '0; m_bvld = 1'b0; end
      2'b00, 2'b10: begin m_valid = bus.if_ce; m_pc = bus.if_pc; m_bvld = 1'b0; end
      default: if (!m_bvld) begin m_buf = bus.inst_sram_rdata; m_bvld = 1'b1; end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int k, input bit we, input logic [4:0] wa,
                         input logic [DATA_W-1:0] wd, input bit pend);
    bus.fwd_we[k]                  = we;
    bus.fwd_waddr[k*5 +: 5]        = wa;
    bus.fwd_wdata[k*DATA_W +: DATA_W] = wd;
    bus.fwd_pend[k]                = pend;
  endtask

  task automatic clr_fwd();
    bus.fwd_we = '0; bus.fwd_waddr = '0; bus.fwd_wdata = '0; bus.fwd_pend = '0;
  endtask

  logic [STALL_W-1:0] st;

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    rst = 1'b0;
    bus.stall = '0; bus.if_ce = 1'b0; bus.if_pc = '0; bus.inst_sram_rdata = '0;
    bus.src_used = '0; bus.perf_clr = 1'b0;
    clr_fwd();
    m_reset();
    step_check("reset");
    rst = 1'b1;

    // Basic forwarding: MEM wins over WB for the same register
    bus.if_ce = 1'b1; bus.if_pc = 32'h40;
    step_check("fwd_cap"); tick();
    bus.inst_sram_rdata = mk(5'd5, 5'd9, 5'd0); bus.src_used = 2'b01;
    set_fwd(0, 1'b0, 5'd5, 32'h5555, 1'b1);
    set_fwd(1, 1'b1, 5'd5, 32'hAAAA0000, 1'b0);
    set_fwd(2, 1'b1, 5'd5, 32'h1111, 1'b0);
    step_check("fwd");
    chk("fwd/src0", bus.src_data[31:0], 32'hAAAA0000);
    chk("fwd/stallreq0", bus.stallreq, 1'b0);
    tick();

    // Load-use interlock
    clr_fwd();
    bus.inst_sram_rdata = mk(5'd7, 5'd0, 5'd0); bus.src_used = 2'b01;
    set_fwd(0, 1'b1, 5'd7, 32'h77, 1'b1);
    bus.stall = 6'b000110;
    step_check("lu");
    chk("lu/stallreq1", bus.stallreq, 1'b1);
    tick();
    chk("lu/cnt_inc", bus.stall_cnt, 4'd1);
    bus.src_used = 2'b00;
    step_check("lu_unused");
    chk("lu_unused/stallreq0", bus.stallreq, 1'b0);
    tick();

    // Replay across a 3-cycle ID stall
    clr_fwd();
    bus.stall = '0; bus.if_ce = 1'b1; bus.if_pc = 32'h80; bus.inst_sram_rdata = 32'h12345678;
    step_check("rp_cap"); tick();
    bus.inst_sram_rdata = 32'h3C011234; bus.stall = 6'b000110;
    step_check("rp0");
    chk("rp0/inst", bus.id_inst, 32'h3C011234);
    tick();
    for (int j = 0; j < 2; j++) begin
      bus.inst_sram_rdata = 32'hDEADBEEF;
      step_check("rp_hold");
      chk("rp_hold/inst", bus.id_inst, 32'h3C011234);
      tick();
    end
    bus.stall = '0; bus.if_pc = 32'h84;
    step_check("rp_last");
    chk("rp_last/inst", bus.id_inst, 32'h3C011234);
    tick();
    bus.inst_sram_rdata = 32'h00221820;
    step_check("rp_new");
    chk("rp_new/pc", bus.id_pc, 32'h84);
    chk("rp_new/inst", bus.id_inst, 32'h00221820);
    tick();

    // Bubble insert with a pending match present
    bus.inst_sram_rdata = mk(5'd3, 5'd0, 5'd0); bus.src_used = 2'b01;
    set_fwd(0, 1'b1, 5'd3, 32'h33, 1'b1);
    bus.stall = 6'b000010;
    step_check("bub_pre"); tick();
    step_check("bub");
    chk("bub/valid", bus.id_valid, 1'b0);
    chk("bub/pc", bus.id_pc, 32'h0);
    chk("bub/inst", bus.id_inst, 32'h0);
    chk("bub/stallreq", bus.stallreq, 1'b0);
    tick();

    // $zero is never forwarded and never stalls
    clr_fwd();
    bus.stall = '0; bus.if_ce = 1'b1; bus.if_pc = 32'h90;
    step_check("zero_cap"); tick();
    bus.inst_sram_rdata = mk(5'd0, 5'd0, 5'd4); bus.src_used = 2'b11;
    set_fwd(0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);
    step_check("zero");
    chk("zero/src0", bus.src_data[31:0], 32'h0);
    chk("zero/stallreq", bus.stallreq, 1'b0);
    tick();

    // Counter saturation under a sustained interlock
    clr_fwd();
    bus.inst_sram_rdata = mk(5'd7, 5'd7, 5'd0); bus.src_used = 2'b01;
    set_fwd(0, 1'b1, 5'd7, 32'h70, 1'b1);
    bus.if_pc = 32'hA0;
    step_check("sat_cap"); tick();
    bus.stall = 6'b000110;
    for (int j = 0; j < 20; j++) begin
      step_check("sat");
      tick();
    end
    chk("sat/cnt", bus.stall_cnt, 4'd15);
    step_check("sat_hold");
    chk("sat_hold/stallreq", bus.stallreq, 1'b1);

    // Asynchronous reset in the middle of the stall
    rst = 1'b0;
    #1;
    m_reset();
    check_all("rst_mid");
    chk("rst_mid/stallreq", bus.stallreq, 1'b0);
    chk("rst_mid/cnt", bus.stall_cnt, 4'd0);
    chk("rst_mid/valid", bus.id_valid, 1'b0);
    #1 rst = 1'b1;
    tick();

    // perf_clr has priority over a concurrent stall
    bus.stall = '0;
    step_check("clr_cap"); tick();
    bus.stall = 6'b000110;
    for (int j = 0; j < 3; j++) begin
      step_check("clr_stall");
      tick();
    end
    bus.perf_clr = 1'b1;
    step_check("clr"); tick();
    bus.perf_clr = 1'b0;
    step_check("clr_after");
    chk("clr_after/cnt", bus.stall_cnt, 4'd0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       st = 6'b000000;
        1:       st = 6'b000010;
        2:       st = 6'b000110;
        default: st = 6'b000100;
      endcase
      bus.stall = st | (6'($urandom) & 6'b111001);
      bus.if_ce = ($urandom_range(0, 3) != 0);
      bus.if_pc = $urandom;
      bus.inst_sram_rdata = {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                             5'($urandom_range(0, 3)), 11'($urandom)};
      bus.src_used = NUM_SRC'($urandom);
      for (int k = 0; k < NUM_FWD; k++)
        set_fwd(k, 1'($urandom), 5'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 2) == 0));
      bus.perf_clr = ($urandom_range(0, 15) == 0);
      step_check("rand");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/id_fwd_interlock.md
Name: id_fwd_interlock

Overview:
- Parametrised successor to the current decode-stage operand path.
- Owns the IF->ID pipeline register and an instruction replay buffer, so the instruction is not lost while ID is stalled on a single-cycle-latency inst SRAM.
- Provides an N-source, M-stage priority forwarding network with load-use interlock and stall request.
- Keeps a saturating stall-cycle performance counter.
- Sits between the IF stage, the regfile read ports and the ID decoder/EX bus packer.

Parameters:
- DATA_W, 32: register and forwarded data width.
- NUM_SRC, 2: source operands, 1..3. Source 0 = inst[25:21], 1 = inst[20:16], 2 = inst[15:11].
- NUM_FWD, 3: forwarding stages. Index 0 is youngest (EX), then MEM, WB.
- STALL_W, 6: stall bus width.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  STALL_W  global stall vector; bit1 = IF held, bit2 = ID held.
- if_ce  in  1  IF slot valid.
- if_pc  in  32  IF pc.
- inst_sram_rdata  in  32  instruction returned one cycle after its pc is presented.
- src_used  in  NUM_SRC  decoder flag, per source: operand actually read by the current id_inst.
- rf_raddr  out  5*NUM_SRC  regfile read addresses, packed, source 0 in the LSBs.
- rf_rdata  in  DATA_W*NUM_SRC  regfile read data, combinational from rf_raddr.
- fwd_we  in  NUM_FWD  per-stage write enable.
- fwd_waddr  in  5*NUM_FWD  per-stage destination.
- fwd_wdata  in  DATA_W*NUM_FWD  per-stage result.
- fwd_pend  in  NUM_FWD  per-stage flag: result not yet available (e.g. load in EX).
- perf_clr  in  1  synchronous clear of stall_cnt.
- id_valid  out  1  ID holds a real instruction.
- id_pc  out  32  ID pc.
- id_inst  out  32  ID instruction; 0 (nop) when !id_valid.
- src_data  out  DATA_W*NUM_SRC  forwarded operand values.
- stallreq  out  1  ID requests a pipeline stall.
- stall_cnt  out  CNT_W  saturating count of stallreq cycles.

Behaviour:
- Reset (rst=0, asynchronous): id_valid=0, id_pc=0, inst_buf=0, buf_vld=0, stall_cnt=0.
  - Hence id_inst=0 and stallreq=0.
- Pipeline register update, in priority order each edge:
  - Bubble: stall[1]=1 and stall[2]=0 -> id_valid=0, id_pc=0, buf_vld=0.
  - Capture: stall[1]=0 -> id_valid=if_ce, id_pc=if_pc, buf_vld=0.
  - Otherwise: hold.
- Replay buffer, state {buf_vld, inst_buf}:
  - On an edge where the register holds, stall[2]=1 and buf_vld=0: inst_buf <= inst_sram_rdata, buf_vld <= 1.
  - While buf_vld=1, inst_buf is frozen.
  - id_inst = !id_valid ? 0 : (buf_vld ? inst_buf : inst_sram_rdata).
- Source address: src_addr[i] is taken from id_inst; rf_raddr = src_addr.
- Forwarding, per source i, purely combinational (same cycle):
  - src_addr[i]==0: data is 0, no hazard; forwarding and regfile are ignored.
  - Otherwise the lowest stage k with fwd_we[k] and fwd_waddr[k]==src_addr[i] wins.
    - Data = fwd_wdata[k]; hazard[i] = fwd_pend[k].
    - A pending younger match masks older matches, and still stalls.
  - No match: data = rf_rdata[i], hazard[i]=0.
- stallreq = id_valid & |(src_used & hazard).
  - Combinational, no added latency. Unused sources never stall.
- stall_cnt:
  - perf_clr has priority -> 0.
  - Otherwise +1 on each edge with stallreq=1.
  - Saturates at all-ones and does not wrap.
- Simultaneous events:
  - Bubble and buffer-fill cannot coincide, because fill needs stall[2]=1.
  - Capture while buf_vld=1: the new instruction wins and the buffer is dropped.
- Reset mid-stall: everything clears immediately; stallreq drops in the same cycle that reset is asserted.
- Multiple stages matching the same address: only the youngest is used; older data is never selected.

Test Plan:
- Basic forwarding:
  - Stimulus: id_inst rs=5; fwd_we=3'b110, waddr[1]=5 with wdata=0xAAAA0000, waddr[2]=5 with wdata=0x1111.
  - Required: src_data[0]=0xAAAA0000, stallreq=0.
- Load-use interlock:
  - Stimulus: rs=7, src_used[0]=1; stage0 we=1, waddr=7, pend=1.
  - Required: stallreq=1 and stall_cnt increments.
  - With src_used[0]=0 instead: stallreq=0.
- Replay across a stall:
  - Stimulus: capture pc=0x80, inst_sram_rdata=0x3C011234; next cycle stall=6'b000110 for 3 cycles while inst_sram_rdata changes to 0xDEADBEEF.
  - Required: id_inst stays 0x3C011234 throughout; the next capture clears buf_vld.
- Bubble insert:
  - Stimulus: stall=6'b000010.
  - Required: next edge id_valid=0, id_pc=0, id_inst=0, stallreq=0 even if a pending match exists.
- $zero handling:
  - Stimulus: rs=0, stage0 we=1, waddr=0, pend=1, wdata=0xFFFFFFFF.
  - Required: src_data[0]=0, stallreq=0.
- Reset and counter:
  - Stimulus: CNT_W=4, force stallreq for 20 cycles.
  - Required: stall_cnt=15, held there (saturated).
  - Then pulse rst low mid-stall: outputs return to reset values asynchronously.
  - Then perf_clr=1: stall_cnt=0 on the next edge.
